// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
//   rf_state_e    : clear-sequencer state encoding (RF_IDLE, RF_SWEEP)
//   rf_merge_byte : byte-lane merge of old/new data under one byte enable
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

    // Byte lane of a partial write: take the new byte only when enabled.
    function automatic logic [7:0] rf_merge_byte(input logic [7:0] old_b,
                                                 input logic [7:0] new_b,
                                                 input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Soft-clear sequencer: walks a pointer over every entry, one per cycle.
// Ports:
//   clk, reset  : clock, async active-high reset
//   clr_req     : start a sweep (only honoured in IDLE)
//   clr_ptr     : entry to zero this cycle (valid while clr_busy)
//   clr_busy    : sweep in progress (straight from the state flop)
//   wr_ready    : writes may be accepted (low during the sweep)
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic [ADDR_W-1:0] clr_ptr,
    output logic              clr_busy,
    output logic              wr_ready
);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RF_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_SWEEP;
                    ptr_d   = '0;
                end
            end
            RF_SWEEP: begin
                // Pointer wraps naturally to 0 on the last entry.
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == {ADDR_W{1'b1}}) state_d = RF_IDLE;
            end
            default: state_d = RF_IDLE;
        endcase
    end

    assign clr_ptr  = ptr_q;
    assign clr_busy = (state_q == RF_SWEEP);
    assign wr_ready = !clr_busy;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one
// synchronous byte-enabled write port, optional zero register, optional
// write-to-read bypass and a sequenced soft clear.
// Ports:
//   clk, reset          : clock, async active-high reset (zeroes the array)
//   rd_addr1/rd_data1   : read port 1
//   rd_addr2/rd_data2   : read port 2
//   wr_en/wr_addr/wr_data/wr_be : write request, byte enables per lane
//   wr_ready            : write accepted when high
//   clr_req/clr_busy    : soft-clear request / sweep in progress
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    rd_addr1,
    output logic [WIDTH-1:0]     rd_data1,
    input  logic [ADDR_W-1:0]    rd_addr2,
    output logic [WIDTH-1:0]     rd_data2,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [WIDTH/8-1:0]   wr_be,
    output logic                 wr_ready,
    input  logic                 clr_req,
    output logic                 clr_busy
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = WIDTH / 8;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [WIDTH-1:0]  wr_merged;
    logic [ADDR_W-1:0] clr_ptr;
    logic              wr_commit;

    regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_ptr  (clr_ptr),
        .clr_busy (clr_busy),
        .wr_ready (wr_ready)
    );

    // Writes to the zero register are accepted but never stored.
    assign wr_commit = wr_en && wr_ready && !(ZERO_REG && (wr_addr == '0));

    always_comb begin
        wr_merged = mem_q[wr_addr];
        for (int k = 0; k < NBYTES; k++)
            wr_merged[8*k +: 8] = rf_merge_byte(mem_q[wr_addr][8*k +: 8],
                                                wr_data[8*k +: 8], wr_be[k]);
    end

    // A write and a sweep step never coincide: wr_ready is low while sweeping.
    always_comb begin
        mem_d = mem_q;
        if (wr_commit) mem_d[wr_addr] = wr_merged;
        if (clr_busy)  mem_d[clr_ptr] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data1 = mem_q[rd_addr1];
        if (BYPASS && wr_commit && (wr_addr == rd_addr1)) rd_data1 = wr_merged;
        if (ZERO_REG && (rd_addr1 == '0))                 rd_data1 = '0;
    end

    always_comb begin
        rd_data2 = mem_q[rd_addr2];
        if (BYPASS && wr_commit && (wr_addr == rd_addr2)) rd_data2 = wr_merged;
        if (ZERO_REG && (rd_addr2 == '0))                 rd_data2 = '0;
    end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    localparam bit BYP = 1'b1;

    logic        clk, reset;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr;
    logic [31:0] rd_data1, rd_data2, wr_data;
    logic        wr_en, wr_ready, clr_req, clr_busy;
    logic [3:0]  wr_be;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [32];

    regfile_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(BYP)) dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_ready(wr_ready), .clr_req(clr_req), .clr_busy(clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m = 32'h0;
        for (int k = 0; k < 4; k++) if (be[k]) m = m | (32'hFF << (8 * k));
        return m;
    endfunction

    function automatic logic [31:0] merged(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
        return (old_v & ~be_mask(be)) | (new_v & be_mask(be));
    endfunction

    // Expected read value given the write presented in the same cycle (accepted).
    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd,
                                           input logic [3:0] be);
        if (ra == 5'd0) return 32'h0;
        if (BYP && we && wa == ra) return merged(model[ra], wd, be);
        return model[ra];
    endfunction

    // Drive one write for a cycle, commit it at the edge, update the model.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(posedge clk);
        if (a != 5'd0) model[a] = merged(model[a], d, be);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a); rd_addr2 = 5'(31 - a);
            #1;
            total += 2;
            if (rd_data1 !== 32'h0) begin bad++; $display("FAIL %s rd1[%0d] got %h want 0", name, a, rd_data1); end
            if (rd_data2 !== 32'h0) begin bad++; $display("FAIL %s rd2[%0d] got %h want 0", name, 31 - a, rd_data2); end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total += 2;
        if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", wr_ready); end
        if (clr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", clr_busy); end
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset_read");
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic test_bypass;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        rd_addr1 = 5'd3; rd_addr2 = 5'd3;
        #1;
        total += 2;
        if (rd_data1 !== (BYP ? 32'hDEADBEEF : 32'h0)) begin bad++; $display("FAIL bypass_rd1 got %h", rd_data1); end
        if (rd_data2 !== (BYP ? 32'hDEADBEEF : 32'h0)) begin bad++; $display("FAIL bypass_rd2 got %h", rd_data2); end
        @(posedge clk);
        model[3] = 32'hDEADBEEF;
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        total++;
        if (rd_data1 !== 32'hDEADBEEF) begin bad++; $display("FAIL write_latency got %h want deadbeef", rd_data1); end
    endtask

    task automatic test_byte_enable;
        do_write(5'd5, 32'h11223344, 4'hF);
        do_write(5'd5, 32'hAABBCCDD, 4'b0101);
        rd_addr1 = 5'd5;
        #1;
        total++;
        if (rd_data1 !== 32'h11BB33DD) begin bad++; $display("FAIL byte_en got %h want 11bb33dd", rd_data1); end
        do_write(5'd6, 32'h55667788, 4'h0);
        rd_addr2 = 5'd6;
        #1;
        total++;
        if (rd_data2 !== 32'h0) begin bad++; $display("FAIL be_zero got %h want 0", rd_data2); end
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; wr_be = 4'hF;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        #1;
        total += 3;
        if (wr_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got %b want 1", wr_ready); end
        if (rd_data1 !== 32'h0) begin bad++; $display("FAIL zero_byp1 got %h want 0", rd_data1); end
        if (rd_data2 !== 32'h0) begin bad++; $display("FAIL zero_byp2 got %h want 0", rd_data2); end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        total += 2;
        if (rd_data1 !== 32'h0) begin bad++; $display("FAIL zero_rd1 got %h want 0", rd_data1); end
        if (rd_data2 !== 32'h0) begin bad++; $display("FAIL zero_rd2 got %h want 0", rd_data2); end
    endtask

    task automatic test_random;
        logic [31:0] e1, e2;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            wr_en = 1'($urandom); wr_addr = 5'($urandom); wr_data = $urandom; wr_be = 4'($urandom);
            rd_addr1 = 5'($urandom);
            rd_addr2 = (n % 4 == 0) ? wr_addr : 5'($urandom);
            #1;
            e1 = exp_rd(rd_addr1, wr_en, wr_addr, wr_data, wr_be);
            e2 = exp_rd(rd_addr2, wr_en, wr_addr, wr_data, wr_be);
            total += 2;
            if (rd_data1 !== e1) begin bad++; $display("FAIL rand_rd1 n=%0d a=%0d got %h want %h", n, rd_addr1, rd_data1, e1); end
            if (rd_data2 !== e2) begin bad++; $display("FAIL rand_rd2 n=%0d a=%0d got %h want %h", n, rd_addr2, rd_data2, e2); end
            @(posedge clk);
            if (wr_en && wr_addr != 5'd0) model[wr_addr] = merged(model[wr_addr], wr_data, wr_be);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_sweep;
        int busy_cnt = 0;
        logic [4:0]  ra;
        logic [31:0] e;
        for (int a = 1; a < 32; a++) do_write(5'(a), 32'(a), 4'hF);
        @(negedge clk);
        clr_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 5) clr_req = 1'b0;   // held high across early sweep cycles
            if (!clr_busy) break;
            busy_cnt++;
            wr_en = (i == 3); wr_addr = 5'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
            ra = 5'($urandom);
            rd_addr1 = 5'd31; rd_addr2 = ra;
            #1;
            // Entries below the sweep index are already cleared.
            e = (ra == 5'd0 || int'(ra) < i) ? 32'h0 : 32'(ra);
            total += 3;
            if (wr_ready !== 1'b0) begin bad++; $display("FAIL sweep_ready i=%0d got %b want 0", i, wr_ready); end
            if (rd_data1 !== 32'd31) begin bad++; $display("FAIL sweep_e31 i=%0d got %h want 31", i, rd_data1); end
            if (rd_data2 !== e) begin bad++; $display("FAIL sweep_rd i=%0d a=%0d got %h want %h", i, ra, rd_data2, e); end
        end
        wr_en = 1'b0;
        total++;
        if (busy_cnt != 32) begin bad++; $display("FAIL sweep_len got %0d want 32", busy_cnt); end
        check_all_zero("after_sweep");
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic test_reset_in_sweep;
        for (int a = 8; a < 16; a++) do_write(5'(a), $urandom | 32'h1, 4'hF);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (9) @(negedge clk);
        total++;
        if (clr_busy !== 1'b1) begin bad++; $display("FAIL rst_sweep_busy got %b want 1", clr_busy); end
        #2 reset = 1'b1;
        #1;
        total += 2;
        if (clr_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", clr_busy); end
        if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", wr_ready); end
        check_all_zero("rst_in_sweep");
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        do_write(5'd9, 32'hCAFEF00D, 4'hF);
        rd_addr1 = 5'd9;
        #1;
        total++;
        if (rd_data1 !== 32'hCAFEF00D) begin bad++; $display("FAIL post_rst_write got %h want cafef00d", rd_data1); end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_addr1 = '0; rd_addr2 = '0; clr_req = 1'b0;
        test_reset;
        test_bypass;
        test_byte_enable;
        test_zero_reg;
        test_random;
        test_sweep;
        test_reset_in_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
